bht_predictor: RTL and testbench
================================

Name: bht_predictor

Overview:
- Branch history table of 2-bit saturating counters, indexed by PC. Supplies a taken/not-taken prediction at fetch/decode.
- Holds each prediction in an in-order in-flight queue until the branch resolves in EX.
- On resolution, trains the counter and presents the aligned {OUTCOME, PREDICTION} pair to the downstream miss comparator, which drives MISS/flush.

Parameters:
- IDX_W, 4, table index width; table has 2**IDX_W entries; index = LOOKUP_PC[IDX_W+1:2]
- DEPTH, 4, in-flight queue entries (power of two, >=2)
- PC_W, 32, PC width

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-low reset
- LOOKUP_VALID  in  1  branch lookup request this cycle
- LOOKUP_PC  in  PC_W  PC of branch being looked up
- PRED_VALID  out  1  prediction valid (one cycle after accepted lookup)
- PRED_TAKEN  out  1  predicted direction, 1 = taken
- QUEUE_FULL  out  1  in-flight queue holds DEPTH entries
- RESOLVE_VALID  in  1  oldest in-flight branch resolved this cycle
- OUTCOME  in  1  actual direction of resolving branch
- FLUSH  in  1  discard all in-flight entries (driven from MISS)
- CMP_VALID  out  1  comparator pair valid
- CMP_OUTCOME  out  1  to comparator OUTCOME
- CMP_PREDICTION  out  1  to comparator PREDICTION
- RES_ERR  out  1  one-cycle pulse: resolve with empty queue

Behaviour:
- Reset (RESET=0 at edge):
  - all counters = 2'b01 (weakly not-taken); queue empty
  - PRED_VALID, PRED_TAKEN, CMP_VALID, CMP_OUTCOME, CMP_PREDICTION, RES_ERR = 0; QUEUE_FULL = 0
  - reset overrides every other input, including mid-resolve and mid-flush.
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Prediction = counter[1].
  - Taken outcome: increment, saturating at 11.
  - Not-taken outcome: decrement, saturating at 00.
- Lookup:
  - Accepted at edge t when LOOKUP_VALID=1 and (not full, or a resolve pop occurs in the same cycle), and FLUSH=0.
  - Accepted lookup pushes {index, prediction} into the queue.
  - PRED_VALID=1 and PRED_TAKEN are registered at t+1 for exactly one cycle.
  - Rejected lookup: PRED_VALID=0 at t+1, nothing pushed; upstream stalls on QUEUE_FULL.
- Resolve:
  - At edge t with RESOLVE_VALID=1 and queue non-empty: pop head and update counter[head.index] with OUTCOME.
  - At t+1: CMP_VALID=1, CMP_OUTCOME=OUTCOME, CMP_PREDICTION=head.pred for one cycle.
  - Resolve with empty queue: no update, CMP_VALID=0, RES_ERR=1 at t+1.
- Same-cycle lookup and resolve to the same index: lookup reads the pre-update counter (no bypass).
- Push and pop in the same cycle when full: both succeed; occupancy unchanged.
- FLUSH at edge t:
  - A same-cycle resolve is processed first (pop, update, CMP outputs).
  - All remaining entries are then cleared; a same-cycle lookup is dropped (PRED_VALID=0 at t+1).
- Occupancy pointers wrap modulo DEPTH. QUEUE_FULL is combinational from the occupancy register.

Optional Feature:
- Macro: BHT_STATS_EN.
- Defined:
  - Adds outputs STAT_LOOKUPS[15:0] (accepted lookups) and STAT_MISSES[15:0] (resolves where OUTCOME != popped prediction).
  - Both counters are zero on reset and saturate at 16'hFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package bht_pkg:
  - 2-bit counter typedef and the four state constants
  - reset value CTR_RESET=2'b01
  - saturating-update function
  - queue-entry struct {index, pred}
- Sub-module bht_inflight_fifo: DEPTH-entry in-order queue with push/pop/flush and full/empty outputs.

Test Plan:
- Reset, then lookup PC=0x10 -> PRED_VALID=1, PRED_TAKEN=0 next cycle; QUEUE_FULL=0.
- Two lookup/resolve cycles at PC=0x10 with OUTCOME=1 -> counter 01→10→11; third lookup PRED_TAKEN=1; CMP_PREDICTION sequence 0,1.
- Push 4 lookups with no resolve -> QUEUE_FULL=1; 5th lookup gives PRED_VALID=0; lookup plus resolve in the same cycle is accepted and QUEUE_FULL stays 1.
- Three queued entries, then RESOLVE_VALID=1, OUTCOME=1 and FLUSH=1 in the same cycle -> CMP_VALID=1 with head pair; queue empty afterwards; following resolve gives RES_ERR=1.
- RESET=0 asserted with two entries queued and a resolve pending -> all outputs 0, counters back to 01, next lookup predicts 0.
- With BHT_STATS_EN defined: 4 resolves with 1 mismatch -> STAT_LOOKUPS=4, STAT_MISSES=1.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared types for the branch history table: 2-bit counter encoding and in-flight queue entry.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bht_pkg;

   // Width of the index field carried in each queue entry; must be >= the predictor's IDX_W.
   localparam int BHT_IDX_W = 4;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT   = 2'b00;
   localparam ctr_t CTR_WNT   = 2'b01;
   localparam ctr_t CTR_WT    = 2'b10;
   localparam ctr_t CTR_ST    = 2'b11;
   localparam ctr_t CTR_RESET = CTR_WNT;

   typedef struct packed {
      logic [BHT_IDX_W-1:0] index;
      logic                 pred;
   } entry_t;

   // Saturating 2-bit update: taken moves toward ST, not-taken toward SNT.
   function automatic ctr_t ctr_update(input ctr_t ctr, input logic taken);
      ctr_t nxt;
      if (taken) begin
         nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
      end else begin
         nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bht_inflight_fifo.sv
// In-order queue of in-flight predictions with push, pop and whole-queue flush.
// Latency: head is combinational from storage; push visible at head one cycle later.
// Backpressure: push refused when full unless a pop happens in the same cycle; flush drops a same-cycle push.
module bht_inflight_fifo
   import bht_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  entry_t push_dat,
   input  logic   pop,
   input  logic   flush,
   output entry_t head_dat,
   output logic   full,
   output logic   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign pop_ok   = pop && !empty;
   // A pop frees the slot the push writes, so full+pop still accepts the push.
   assign push_ok  = push && (!full || pop_ok) && !flush;
   assign head_dat = mem[rd_ptr];

   // Pointer and occupancy tracking; flush empties the queue after any same-cycle pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table of 2-bit counters with an in-order in-flight queue feeding the miss comparator.
// Latency: prediction and comparator pair are registered, one cycle after the accepted lookup/resolve.
// Backpressure: QUEUE_FULL stalls lookups (a same-cycle resolve frees a slot); FLUSH drops lookups. Optional BHT_STATS_EN adds counters.
module bht_predictor
   import bht_pkg::*;
#(
   parameter int IDX_W = 4,
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
)
(
   input  logic            CLK,
   input  logic            RESET,
   input  logic            LOOKUP_VALID,
   input  logic [PC_W-1:0] LOOKUP_PC,
   output logic            PRED_VALID,
   output logic            PRED_TAKEN,
   output logic            QUEUE_FULL,
   input  logic            RESOLVE_VALID,
   input  logic            OUTCOME,
   input  logic            FLUSH,
   output logic            CMP_VALID,
   output logic            CMP_OUTCOME,
   output logic            CMP_PREDICTION,
   output logic            RES_ERR
`ifdef BHT_STATS_EN
   ,
   output logic [15:0]     STAT_LOOKUPS,
   output logic [15:0]     STAT_MISSES
`endif
);

   ctr_t             ctr_q [2**IDX_W];
   logic [IDX_W-1:0] lookup_idx;
   logic [IDX_W-1:0] head_idx;
   logic             lookup_pred;
   logic             q_full;
   logic             q_empty;
   logic             pop;
   logic             accept;
   entry_t           push_ent;
   entry_t           head;
   logic             unused_pc_bits;

   // Word-aligned PC: the two low bits and the bits above the index never select an entry.
   assign lookup_idx     = LOOKUP_PC[IDX_W+1:2];
   assign unused_pc_bits = ^{LOOKUP_PC[PC_W-1:IDX_W+2], LOOKUP_PC[1:0]};

   // Read the pre-update counter: a same-cycle resolve to this index is not bypassed.
   assign lookup_pred = ctr_q[lookup_idx][1];

   assign pop    = RESOLVE_VALID && !q_empty;
   assign accept = LOOKUP_VALID && (!q_full || pop) && !FLUSH;

   assign push_ent.index = BHT_IDX_W'(lookup_idx);
   assign push_ent.pred  = lookup_pred;
   assign head_idx       = IDX_W'(head.index);
   assign QUEUE_FULL     = q_full;

   bht_inflight_fifo #(
      .DEPTH    (DEPTH)
   ) u_fifo (
      .clk      (CLK),
      .rst_n    (RESET),
      .push     (accept),
      .push_dat (push_ent),
      .pop      (RESOLVE_VALID),
      .flush    (FLUSH),
      .head_dat (head),
      .full     (q_full),
      .empty    (q_empty)
   );

   // Train the counter of the resolving branch; reset returns every entry to weakly not-taken.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int i = 0; i < 2**IDX_W; i++) begin
            ctr_q[i] <= CTR_RESET;
         end
      end else if (pop) begin
         ctr_q[head_idx] <= ctr_update(ctr_q[head_idx], OUTCOME);
      end
   end

   // Registered one-cycle prediction, comparator pair and empty-resolve error pulse.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         PRED_VALID     <= 1'b0;
         PRED_TAKEN     <= 1'b0;
         CMP_VALID      <= 1'b0;
         CMP_OUTCOME    <= 1'b0;
         CMP_PREDICTION <= 1'b0;
         RES_ERR        <= 1'b0;
      end else begin
         PRED_VALID     <= accept;
         PRED_TAKEN     <= accept && lookup_pred;
         CMP_VALID      <= pop;
         CMP_OUTCOME    <= pop && OUTCOME;
         CMP_PREDICTION <= pop && head.pred;
         RES_ERR        <= RESOLVE_VALID && q_empty;
      end
   end

`ifdef BHT_STATS_EN
   // Saturating counts of accepted lookups and resolves whose outcome disagreed with the prediction.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         STAT_LOOKUPS <= 16'd0;
         STAT_MISSES  <= 16'd0;
      end else begin
         if (accept && (STAT_LOOKUPS != 16'hFFFF)) STAT_LOOKUPS <= STAT_LOOKUPS + 16'd1;
         if (pop && (OUTCOME != head.pred) && (STAT_MISSES != 16'hFFFF)) STAT_MISSES <= STAT_MISSES + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: reset, training/saturation, full queue, flush, mid-run reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises full-queue rejection and push-with-pop acceptance.
module tb_bht_predictor;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        LOOKUP_VALID;
   logic [31:0] LOOKUP_PC;
   logic        PRED_VALID;
   logic        PRED_TAKEN;
   logic        QUEUE_FULL;
   logic        RESOLVE_VALID;
   logic        OUTCOME;
   logic        FLUSH;
   logic        CMP_VALID;
   logic        CMP_OUTCOME;
   logic        CMP_PREDICTION;
   logic        RES_ERR;
`ifdef BHT_STATS_EN
   logic [15:0] STAT_LOOKUPS;
   logic [15:0] STAT_MISSES;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        is_res;
      logic [31:0] arg;
      logic        exp;
   } step_t;

   always #5 CLK = ~CLK;

   bht_predictor #(.IDX_W(4), .DEPTH(4), .PC_W(32)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .LOOKUP_VALID   (LOOKUP_VALID),
      .LOOKUP_PC      (LOOKUP_PC),
      .PRED_VALID     (PRED_VALID),
      .PRED_TAKEN     (PRED_TAKEN),
      .QUEUE_FULL     (QUEUE_FULL),
      .RESOLVE_VALID  (RESOLVE_VALID),
      .OUTCOME        (OUTCOME),
      .FLUSH          (FLUSH),
      .CMP_VALID      (CMP_VALID),
      .CMP_OUTCOME    (CMP_OUTCOME),
      .CMP_PREDICTION (CMP_PREDICTION),
      .RES_ERR        (RES_ERR)
`ifdef BHT_STATS_EN
      ,
      .STAT_LOOKUPS   (STAT_LOOKUPS),
      .STAT_MISSES    (STAT_MISSES)
`endif
   );

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle;
      LOOKUP_VALID  = 1'b0;
      LOOKUP_PC     = 32'd0;
      RESOLVE_VALID = 1'b0;
      OUTCOME       = 1'b0;
      FLUSH         = 1'b0;
   endtask

   task automatic test_reset;
      RESET = 1'b0;
      idle();
      tick();
      tick();
      checks++; if (PRED_VALID !== 1'b0) begin errors++; $display("FAIL reset_pred_valid: got %b want 0", PRED_VALID); end
      checks++; if (PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b want 0", PRED_TAKEN); end
      checks++; if (CMP_VALID !== 1'b0) begin errors++; $display("FAIL reset_cmp_valid: got %b want 0", CMP_VALID); end
      checks++; if (CMP_OUTCOME !== 1'b0) begin errors++; $display("FAIL reset_cmp_outcome: got %b want 0", CMP_OUTCOME); end
      checks++; if (CMP_PREDICTION !== 1'b0) begin errors++; $display("FAIL reset_cmp_prediction: got %b want 0", CMP_PREDICTION); end
      checks++; if (RES_ERR !== 1'b0) begin errors++; $display("FAIL reset_res_err: got %b want 0", RES_ERR); end
      checks++; if (QUEUE_FULL !== 1'b0) begin errors++; $display("FAIL reset_queue_full: got %b want 0", QUEUE_FULL); end
      RESET = 1'b1;
      tick();
   endtask

   task automatic test_first_lookup;
      LOOKUP_VALID = 1'b1;
      LOOKUP_PC    = 32'h10;
      tick();
      idle();
      checks++; if (PRED_VALID !== 1'b1) begin errors++; $display("FAIL first_pred_valid: got %b want 1", PRED_VALID); end
      checks++; if (PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL first_pred_taken: got %b want 0", PRED_TAKEN); end
      checks++; if (QUEUE_FULL !== 1'b0) begin errors++; $display("FAIL first_queue_full: got %b want 0", QUEUE_FULL); end
      tick();
      checks++; if (PRED_VALID !== 1'b0) begin errors++; $display("FAIL first_pred_pulse: got %b want 0", PRED_VALID); end
   endtask

   // Counter at index 4 walks 01->10->11(sat)->10->01->00->00(sat)->01; 0x50 aliases index 4.
   task automatic test_training;
      step_t steps [17];
      steps = '{
         '{1'b1, 32'd1,  1'b0},
         '{1'b0, 32'h10, 1'b1},
         '{1'b1, 32'd1,  1'b1},
         '{1'b0, 32'h10, 1'b1},
         '{1'b0, 32'h14, 1'b0},
         '{1'b1, 32'd1,  1'b1},
         '{1'b1, 32'd0,  1'b0},
         '{1'b0, 32'h50, 1'b1},
         '{1'b1, 32'd0,  1'b1},
         '{1'b0, 32'h10, 1'b1},
         '{1'b1, 32'd0,  1'b1},
         '{1'b0, 32'h10, 1'b0},
         '{1'b1, 32'd0,  1'b0},
         '{1'b0, 32'h10, 1'b0},
         '{1'b1, 32'd0,  1'b0},
         '{1'b0, 32'h10, 1'b0},
         '{1'b1, 32'd1,  1'b0}
      };
      for (int s = 0; s < 17; s++) begin
         idle();
         if (steps[s].is_res) begin
            RESOLVE_VALID = 1'b1;
            OUTCOME       = steps[s].arg[0];
         end else begin
            LOOKUP_VALID = 1'b1;
            LOOKUP_PC    = steps[s].arg;
         end
         tick();
         if (steps[s].is_res) begin
            checks++; if (CMP_VALID !== 1'b1 || CMP_OUTCOME !== steps[s].arg[0]) begin errors++; $display("FAIL train_cmp[%0d]: got valid=%b outcome=%b want valid=1 outcome=%b", s, CMP_VALID, CMP_OUTCOME, steps[s].arg[0]); end
            checks++; if (CMP_PREDICTION !== steps[s].exp) begin errors++; $display("FAIL train_cmp_pred[%0d]: got %b want %b", s, CMP_PREDICTION, steps[s].exp); end
         end else begin
            checks++; if (PRED_VALID !== 1'b1) begin errors++; $display("FAIL train_pred_valid[%0d]: got %b want 1", s, PRED_VALID); end
            checks++; if (PRED_TAKEN !== steps[s].exp) begin errors++; $display("FAIL train_pred_taken[%0d]: got %b want %b", s, PRED_TAKEN, steps[s].exp); end
         end
      end
      idle();
   endtask

   task automatic test_full;
      logic [3:0] outs;
      outs = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         LOOKUP_VALID = 1'b1;
         LOOKUP_PC    = 32'h20 + 32'(4 * i);
         tick();
         checks++; if (PRED_VALID !== 1'b1) begin errors++; $display("FAIL full_push_valid[%0d]: got %b want 1", i, PRED_VALID); end
         checks++; if (QUEUE_FULL !== (i == 3)) begin errors++; $display("FAIL full_flag[%0d]: got %b want %b", i, QUEUE_FULL, (i == 3)); end
      end
      LOOKUP_PC = 32'h10;
      tick();
      checks++; if (PRED_VALID !== 1'b0) begin errors++; $display("FAIL full_reject: got %b want 0", PRED_VALID); end
      checks++; if (QUEUE_FULL !== 1'b1) begin errors++; $display("FAIL full_hold: got %b want 1", QUEUE_FULL); end
      // Push+pop while full; lookup to the resolving index must see the old counter (01).
      LOOKUP_PC     = 32'h20;
      RESOLVE_VALID = 1'b1;
      OUTCOME       = 1'b1;
      tick();
      idle();
      checks++; if (PRED_VALID !== 1'b1 || PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL full_pushpop_pred: got valid=%b taken=%b want 1 0", PRED_VALID, PRED_TAKEN); end
      checks++; if (CMP_VALID !== 1'b1 || CMP_PREDICTION !== 1'b0) begin errors++; $display("FAIL full_pushpop_cmp: got valid=%b pred=%b want 1 0", CMP_VALID, CMP_PREDICTION); end
      checks++; if (QUEUE_FULL !== 1'b1) begin errors++; $display("FAIL full_pushpop_full: got %b want 1", QUEUE_FULL); end
      for (int i = 0; i < 4; i++) begin
         RESOLVE_VALID = 1'b1;
         OUTCOME       = outs[i];
         tick();
         checks++; if (CMP_VALID !== 1'b1 || CMP_PREDICTION !== 1'b0) begin errors++; $display("FAIL drain_cmp[%0d]: got valid=%b pred=%b want 1 0", i, CMP_VALID, CMP_PREDICTION); end
         checks++; if (QUEUE_FULL !== 1'b0) begin errors++; $display("FAIL drain_full[%0d]: got %b want 0", i, QUEUE_FULL); end
      end
      idle();
   endtask

   // Index 8 is now 11, index 9 is 00, index 4 is 01.
   task automatic test_flush;
      LOOKUP_VALID = 1'b1;
      LOOKUP_PC    = 32'h20;
      tick();
      checks++; if (PRED_TAKEN !== 1'b1) begin errors++; $display("FAIL flush_setup_pred: got %b want 1", PRED_TAKEN); end
      LOOKUP_PC = 32'h24;
      tick();
      LOOKUP_PC = 32'h10;
      tick();
      RESOLVE_VALID = 1'b1;
      OUTCOME       = 1'b1;
      FLUSH         = 1'b1;
      LOOKUP_PC     = 32'h20;
      tick();
      idle();
      checks++; if (CMP_VALID !== 1'b1 || CMP_PREDICTION !== 1'b1 || CMP_OUTCOME !== 1'b1) begin errors++; $display("FAIL flush_cmp: got valid=%b pred=%b out=%b want 1 1 1", CMP_VALID, CMP_PREDICTION, CMP_OUTCOME); end
      checks++; if (PRED_VALID !== 1'b0) begin errors++; $display("FAIL flush_drop_lookup: got %b want 0", PRED_VALID); end
      RESOLVE_VALID = 1'b1;
      tick();
      idle();
      checks++; if (RES_ERR !== 1'b1) begin errors++; $display("FAIL flush_res_err: got %b want 1", RES_ERR); end
      checks++; if (CMP_VALID !== 1'b0) begin errors++; $display("FAIL flush_empty_cmp: got %b want 0", CMP_VALID); end
      tick();
      checks++; if (RES_ERR !== 1'b0) begin errors++; $display("FAIL res_err_pulse: got %b want 0", RES_ERR); end
   endtask

   task automatic test_reset_mid;
      LOOKUP_VALID = 1'b1;
      LOOKUP_PC    = 32'h20;
      tick();
      LOOKUP_PC = 32'h24;
      tick();
      RESET         = 1'b0;
      RESOLVE_VALID = 1'b1;
      OUTCOME       = 1'b1;
      LOOKUP_PC     = 32'h20;
      tick();
      checks++; if ({PRED_VALID, PRED_TAKEN, CMP_VALID, CMP_OUTCOME, CMP_PREDICTION, RES_ERR, QUEUE_FULL} !== 7'b0) begin errors++; $display("FAIL midreset_outputs: got %b want 0000000", {PRED_VALID, PRED_TAKEN, CMP_VALID, CMP_OUTCOME, CMP_PREDICTION, RES_ERR, QUEUE_FULL}); end
      RESET = 1'b1;
      idle();
      tick();
      LOOKUP_VALID = 1'b1;
      LOOKUP_PC    = 32'h20;
      tick();
      idle();
      checks++; if (PRED_VALID !== 1'b1 || PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL midreset_relookup: got valid=%b taken=%b want 1 0", PRED_VALID, PRED_TAKEN); end
      RESOLVE_VALID = 1'b1;
      OUTCOME       = 1'b1;
      tick();
      checks++; if (CMP_VALID !== 1'b1 || CMP_PREDICTION !== 1'b0) begin errors++; $display("FAIL midreset_head: got valid=%b pred=%b want 1 0", CMP_VALID, CMP_PREDICTION); end
      tick();
      idle();
      checks++; if (RES_ERR !== 1'b1) begin errors++; $display("FAIL midreset_empty: got %b want 1", RES_ERR); end
   endtask

`ifdef BHT_STATS_EN
   task automatic test_stats;
      logic [3:0] outs;
      outs = 4'b0100;
      RESET = 1'b0;
      idle();
      tick();
      RESET = 1'b1;
      checks++; if (STAT_LOOKUPS !== 16'd0 || STAT_MISSES !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d %0d want 0 0", STAT_LOOKUPS, STAT_MISSES); end
      for (int i = 0; i < 4; i++) begin
         LOOKUP_VALID = 1'b1;
         LOOKUP_PC    = 32'h40 + 32'(4 * i);
         tick();
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         RESOLVE_VALID = 1'b1;
         OUTCOME       = outs[i];
         tick();
      end
      idle();
      tick();
      checks++; if (STAT_LOOKUPS !== 16'd4) begin errors++; $display("FAIL stats_lookups: got %0d want 4", STAT_LOOKUPS); end
      checks++; if (STAT_MISSES !== 16'd1) begin errors++; $display("FAIL stats_misses: got %0d want 1", STAT_MISSES); end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b0;
      idle();
      test_reset();
      test_first_lookup();
      test_training();
      test_full();
      test_flush();
      test_reset_mid();
`ifdef BHT_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
